regsram_ctrl: RTL

Sequencing and arbitration controller for the 32-entry × 32-bit synchronous register-file SRAM. After reset, or on request, it clears every entry through the SRAM's initialization port. It then shares the SRAM's single normal read/write port between two pipeline requesters using round-robin arbitration with valid/ready handshakes and a one-cycle read-response path. It sits between the decode/writeback stages and the SRAM macro, and is the only block that drives the SRAM's ports.

---
 rtl/regsram_pkg.sv | 19 +
 rtl/regsram_ctrl_if.sv | 23 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/regsram_ctrl.sv | 130 +++++++++++++
 4 files changed

// File: rtl/regsram_pkg.sv
// Shared types and default geometry for the register-file SRAM controller.
package regsram_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

    typedef enum logic {
        INIT  = 1'b0,
        SERVE = 1'b1
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/regsram_ctrl_if.sv
// One requester port of the register-file SRAM controller: request handshake plus read response.
interface regsram_ctrl_if #(
    parameter int DATA_W = regsram_pkg::DEF_DATA_W,
    parameter int ADDR_W = regsram_pkg::DEF_ADDR_W
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins the next tie.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] valid,
    output logic [1:0] grant
);
    logic ptr;

    always_comb begin
        grant = valid;
        if (valid == 2'b11) grant = ptr ? 2'b10 : 2'b01;
    end

    // The pointer only moves when a grant is actually consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (en && (valid != 2'b00)) begin
            ptr <= ~grant[1];
        end
    end
endmodule

// File: rtl/regsram_ctrl.sv
// Clears the register-file SRAM after reset/clear_req, then arbitrates its single port between two requesters.
// Optional feature: define REGSRAM_X0_ZERO_EN to make address 0 a hardwired-zero entry.
module regsram_ctrl
    import regsram_pkg::*;
#(
    parameter int                DATA_W      = DEF_DATA_W,
    parameter int                ADDR_W      = DEF_ADDR_W,
    parameter int                DEPTH       = DEF_DEPTH,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_req,
    output logic              init_done,
    regsram_ctrl_if.slave     p0,
    regsram_ctrl_if.slave     p1,
    output logic              sram_ce,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_init_en,
    output logic              sram_init_we,
    output logic [ADDR_W-1:0] sram_init_addr,
    output logic [DATA_W-1:0] sram_init_data
);
    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              serve;
    logic [1:0]        grant;
    logic              accept;
    req_t              req0, req1, win_req;
    logic              rsp_vld_p1;
    logic              rsp_tag_p1;
    logic [DATA_W-1:0] rsp_data;

    assign serve     = (state == SERVE);
    assign init_done = serve;

    assign req0 = '{we: p0.req_we, addr: p0.req_addr, wdata: p0.req_wdata};
    assign req1 = '{we: p1.req_we, addr: p1.req_addr, wdata: p1.req_wdata};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (serve),
        .valid ({p1.req_valid, p0.req_valid}),
        .grant (grant)
    );

    assign p0.req_ready = serve & grant[0];
    assign p1.req_ready = serve & grant[1];
    assign accept       = serve & (grant != 2'b00);
    assign win_req      = grant[1] ? req1 : req0;

    // Normal port: driven straight from the winning request so the SRAM sees it this cycle.
    always_comb begin
        sram_ce    = accept;
        sram_we    = accept & win_req.we;
        sram_addr  = win_req.addr;
        sram_wdata = win_req.wdata;
`ifdef REGSRAM_X0_ZERO_EN
        if (win_req.we && (win_req.addr == '0)) sram_ce = 1'b0;
`endif
    end

    assign sram_init_en   = ~serve;
    assign sram_init_we   = ~serve;
    assign sram_init_addr = cnt;
    assign sram_init_data = CLEAR_VALUE;

    // Sequencer: clear sweep followed by service; clear_req restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            case (state)
                INIT: begin
                    if (clear_req) begin
                        cnt <= '0;
                    end else if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= SERVE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                SERVE: begin
                    if (clear_req) begin
                        state <= INIT;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= INIT;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Stage p0 -> p1: remember which port owns the read returning next cycle.
    always_ff @(posedge clk) begin
        if (rst) rsp_vld_p1 <= 1'b0;
        else     rsp_vld_p1 <= accept & ~win_req.we;
    end

`ifdef REGSRAM_X0_ZERO_EN
    logic rsp_zero_p1;

    always_ff @(posedge clk) begin
        rsp_tag_p1  <= grant[1];
        rsp_zero_p1 <= (win_req.addr == '0);
    end

    assign rsp_data = rsp_zero_p1 ? '0 : sram_rdata;
`else
    always_ff @(posedge clk) begin
        rsp_tag_p1 <= grant[1];
    end

    assign rsp_data = sram_rdata;
`endif

    assign p0.rsp_valid = rsp_vld_p1 & ~rsp_tag_p1;
    assign p1.rsp_valid = rsp_vld_p1 &  rsp_tag_p1;
    assign p0.rsp_data  = rsp_data;
    assign p1.rsp_data  = rsp_data;
endmodule
